// File: rtl/cpu_core_p.sv
// Multi-cycle 16-bit-instruction core with req/ack ROM and RAM ports; FETCH/EXEC/MEM/HALT FSM.
// Optional multiplier on opcode E is enabled by defining CPU_MUL_EN (otherwise E is a NOP).
module cpu_core_p #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 6,
  parameter int REG_N    = 16,
  parameter int RESET_PC = 0
) (
  input  logic              clk_main,
  input  logic              reset,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_req,
  input  logic              rom_ack,
  input  logic [15:0]       rom_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              ram_we,
  output logic              ram_req,
  input  logic              ram_ack,
  output logic              halted,
  output logic [ADDR_W-1:0] pc_out
);

  localparam int RI_W = $clog2(REG_N);
  localparam logic [ADDR_W-1:0] PC0 = ADDR_W'(RESET_PC);

  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_HALT} state_t;

  state_t            state, state_nxt;
  logic              run;
  logic [15:0]       ir;
  logic              z;
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] regs [REG_N];

  logic [3:0]        op;
  logic [RI_W-1:0]   dr, sa, sb;
  logic [DATA_W-1:0] src_a, src_b, alu_res;
  logic              alu_wr, z_wr;
  logic [ADDR_W-1:0] pc_inc, off_ext;

  assign op      = ir[15:12];
  assign dr      = ir[8 +: RI_W];
  assign sa      = ir[4 +: RI_W];
  assign sb      = ir[0 +: RI_W];
  assign src_a   = regs[sa];
  assign src_b   = regs[sb];
  assign pc_inc  = pc + ADDR_W'(1);
  assign off_ext = ADDR_W'($signed(ir[11:4]));

  always_comb begin
    alu_res = '0;
    alu_wr  = 1'b0;
    z_wr    = 1'b0;
    case (op)
      4'h1: begin alu_res = src_a + src_b;  alu_wr = 1'b1; z_wr = 1'b1; end
      4'h2: begin alu_res = src_a - src_b;  alu_wr = 1'b1; z_wr = 1'b1; end
      4'h3: begin alu_res = src_a & src_b;  alu_wr = 1'b1; z_wr = 1'b1; end
      4'h4: begin alu_res = src_a | src_b;  alu_wr = 1'b1; z_wr = 1'b1; end
      4'h5: begin alu_res = src_a ^ src_b;  alu_wr = 1'b1; z_wr = 1'b1; end
      4'h6: begin alu_res = ~src_a;         alu_wr = 1'b1; z_wr = 1'b1; end
      4'h7: begin alu_res = src_a << 1;     alu_wr = 1'b1; z_wr = 1'b1; end
      4'h8: begin alu_res = src_a >> 1;     alu_wr = 1'b1; z_wr = 1'b1; end
      4'h9: begin alu_res = DATA_W'($signed(ir[7:0])); alu_wr = 1'b1; end
`ifdef CPU_MUL_EN
      4'hE: begin alu_res = src_a * src_b;  alu_wr = 1'b1; z_wr = 1'b1; end
`endif
      default: ;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH: if (run && rom_ack) state_nxt = S_EXEC;
      S_EXEC: begin
        if (op == 4'hA || op == 4'hB) state_nxt = S_MEM;
        else if (op == 4'hF)          state_nxt = S_HALT;
        else                          state_nxt = S_FETCH;
      end
      S_MEM:   if (ram_ack) state_nxt = S_FETCH;
      default: state_nxt = S_HALT;
    endcase
  end

  // run holds off the first fetch until one clock after reset release
  always_ff @(posedge clk_main or negedge reset) begin
    if (!reset) begin
      state     <= S_FETCH;
      run       <= 1'b0;
      ir        <= '0;
      z         <= 1'b0;
      pc        <= PC0;
      ram_addr  <= '0;
      ram_wdata <= '0;
    end else begin
      run   <= 1'b1;
      state <= state_nxt;
      if (state == S_FETCH && run && rom_ack) ir <= rom_data;
      if (state == S_EXEC) begin
        if (z_wr) z <= (alu_res == '0);
        case (op)
          4'hA, 4'hB: begin
            ram_addr  <= ADDR_W'(src_a);
            ram_wdata <= src_b;
          end
          4'hC:    pc <= z ? pc_inc + off_ext : pc_inc;
          4'hD:    pc <= ADDR_W'(src_a);
          4'hF:    ;
          default: pc <= pc_inc;
        endcase
      end
      if (state == S_MEM && ram_ack) pc <= pc_inc;
    end
  end

  always_ff @(posedge clk_main or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < REG_N; i++) regs[i] <= '0;
    end else if (state == S_EXEC && alu_wr) begin
      regs[dr] <= alu_res;
    end else if (state == S_MEM && ram_ack && op == 4'hA) begin
      regs[dr] <= ram_rdata;
    end
  end

  assign rom_req = run && (state == S_FETCH);
  assign rom_addr = pc;
  assign pc_out   = pc;
  assign ram_req  = (state == S_MEM);
  assign ram_we   = (state == S_MEM) && (op == 4'hB);
  assign halted   = (state == S_HALT);

endmodule

// File: doc/cpu_core_p.md
# cpu_core_p

Parametrised multi-cycle successor to the fixed 16-bit/6-bit-address CPU top. It merges control path and datapath into one core and separates the RAM bus into read and write data. It adds req/ack handshakes on both the instruction ROM and the data RAM, so memories may insert wait states. It sits between the instruction ROM and data RAM at the top of the design and executes a fixed 16-bit instruction format.

## Interface
- DATA_W, 16, register/ALU/RAM data width (8..32)
- ADDR_W, 6, ROM and RAM address width (4..16)
- REG_N, 16, register count, power of two, 4..16; register index = field mod REG_N
- RESET_PC, 0, PC value loaded at reset
- clk_main  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low; core held in reset while low
- rom_addr  out  ADDR_W  instruction address (= PC)
- rom_req  out  1  instruction fetch request, held until ack
- rom_ack  in  1  ROM data valid this cycle
- rom_data  in  16  instruction word
- ram_addr  out  ADDR_W  data address
- ram_wdata  out  DATA_W  store data
- ram_rdata  in  DATA_W  load data, sampled on ram_ack
- ram_we  out  1  1 = store, 0 = load; meaningful only with ram_req
- ram_req  out  1  data access request, held until ack
- ram_ack  in  1  RAM access complete this cycle
- halted  out  1  core executed HALT
- pc_out  out  ADDR_W  current PC (debug)

## Operation
- Instruction fields: [15:12] op, [11:8] DR, [7:4] SA, [3:0] SB; imm8 = [7:0] for LDI; off8 = [11:4] for BZ.
- Opcodes:
  - 0 NOP
  - 1 ADD
  - 2 SUB
  - 3 AND
  - 4 OR
  - 5 XOR
  - 6 NOT R[SA]
  - 7 SHL R[SA] by 1
  - 8 SHR R[SA] by 1, logical
  - 9 LDI: R[DR] <= sext(imm8)
  - A LD: R[DR] <= M[R[SA]]
  - B ST: M[R[SA]] <= R[SB]
  - C BZ: if Z, PC <= PC+1+sext(off8)
  - D JMP: PC <= R[SA]
  - E MUL (see Configuration)
  - F HALT
- Binary ops compute R[DR] <= R[SA] op R[SB], truncated to DATA_W.
- Z flag <= (result == 0) on ops 1–8 and E only; all other ops leave Z unchanged.
- Register-sourced addresses use the low ADDR_W bits. PC arithmetic wraps modulo 2^ADDR_W.
- FSM states:
  - FETCH: rom_req=1. On rom_ack, latch rom_data into IR and go to EXEC.
  - EXEC: ALU result and writeback, LDI, BZ, JMP, PC update. LD/ST go to MEM, HALT goes to HALT, everything else returns to FETCH.
  - MEM: ram_req=1, with ram_addr/ram_we/ram_wdata stable. On ram_ack, LD writes R[DR] from ram_rdata, PC <= PC+1, then FETCH.
  - HALT: halted=1, no requests issued. Exit only by reset.
- rom_ack outside FETCH and ram_ack outside MEM are ignored.

## Timing
- Reset values:
  - pc_out = rom_addr = RESET_PC
  - rom_req = ram_req = ram_we = halted = 0
  - ram_addr = ram_wdata = 0
  - all registers 0, Z = 0, state = FETCH
- First rom_req is asserted in the first cycle after reset deasserts.
- Fastest instruction (ack in the same cycle as req): ALU/LDI/BZ/JMP/NOP take 2 cycles; LD/ST take 3 cycles. Each wait cycle adds 1.
- Register-file write, Z update and PC update take effect at the EXEC clock edge, or at the ack edge for LD.
- Reset asserted mid-FETCH or mid-MEM drops rom_req/ram_req asynchronously. The transaction is abandoned and a late ack is ignored.
- ST with ram_ack: memory is written exactly once. The core never re-issues a request after ack.

## Configuration
- CPU_MUL_EN defined: opcode E computes R[DR] <= low DATA_W bits of R[SA]*R[SB] and updates Z; timing is the same as ADD.
- CPU_MUL_EN undefined: opcode E behaves as NOP. No multiplier is synthesised and Z is unchanged.

## Test plan
- Reset: hold reset low 3 cycles with RESET_PC=5. All outputs must equal their reset values, and rom_req rises with rom_addr=5 one cycle after release.
- ALU: LDI R1,3; LDI R2,-3; ADD R3,R1,R2. R3 must be 0 and Z=1, with 2 cycles per instruction at zero-wait ack.
- Memory with waits: LDI R1,7; LDI R4,0x2A; ST [R1],R4; LD R5,[R1], with ram_ack delayed 3 cycles. ram_addr=7 and ram_wdata=0x2A are held stable, R5 = 0x2A, ST occupies 6 cycles, and exactly one write occurs.
- Branch and wrap (ADDR_W=6): BZ with Z=1 at PC=62, off8=+3. PC must become 2. The same instruction with Z=0 gives PC=63.
- HALT and reset mid-op: after HALT, halted=1 and no req for 20 cycles. Drop reset during a FETCH stalled by rom_ack=0. rom_req falls immediately and restarts at RESET_PC after release.
- MUL: R1=6, R2=7, op E. R3 = 42 with CPU_MUL_EN defined; R3 unchanged and Z unchanged when undefined.
